bin_to_bcd_converter: RTL

- Sequential double-dabble converter: turns an unsigned binary result (e.g. an MMA output element) into packed BCD digits.
- Sits directly upstream of the 7-segment display driver. Its BCD output drives that driver's 32-bit hex input, so results display in decimal.
- Uses a valid/ready input handshake. The output register holds the last completed result stable while the next conversion runs, so the display never flickers through intermediate values.

---
 rtl/bin_to_bcd_converter_pkg.sv | 24 ++
 rtl/bin_to_bcd_converter_if.sv | 31 +++
 rtl/bin_to_bcd_converter_digit_adjust.sv | 12 +
 rtl/bin_to_bcd_converter.sv | 88 ++++++++
 4 files changed

// File: rtl/bin_to_bcd_converter_pkg.sv
// Shared types and constants for the double-dabble binary-to-BCD converter.
// The package name is used as the import name in every other file of the block.
package bin_to_bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] NIBBLE_ADJ_THRESH = 4'd5;
  localparam logic [3:0] NIBBLE_ADJ        = 4'd3;

  // Largest value that fits in 'digits' BCD digits (10^digits - 1).
  // The result is returned 64 bits wide so callers can compare it against any input width.
  function automatic logic [63:0] bcd_max(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_converter_if.sv
// Input handshake and result bus of the converter.
// The master side offers a value; the slave side converts it and holds the BCD result.
interface bin_to_bcd_converter_if
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 8
);
  // in_valid/in_ready: a value transfers on a rising edge where both are high.
  // in_ready is high only while the converter is idle. in_valid is ignored
  // while a conversion is running and is never queued.
  logic                  in_valid;
  logic [BIN_WIDTH-1:0]  in_value;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic                  done;
  logic                  busy;
  state_t                state;

  modport master (
    output in_valid, in_value,
    input  in_ready, bcd, overflow, done, busy, state
  );

  modport slave (
    input  in_valid, in_value,
    output in_ready, bcd, overflow, done, busy, state
  );

endinterface

// File: rtl/bin_to_bcd_converter_digit_adjust.sv
// Combinational single-digit double-dabble step.
// Adds 3 to a nibble of 5 or more so that the following left shift carries correctly in decimal.
module bcd_digit_adjust
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= NIBBLE_ADJ_THRESH) ? (digit_i + NIBBLE_ADJ) : digit_i;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble converter: one input bit per cycle, BIN_WIDTH cycles per result.
// The bcd/overflow outputs hold the last completed result while the next conversion runs.
module bin_to_bcd_converter
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 8
)(
  input  logic clk,
  input  logic reset,
  bin_to_bcd_converter_if.slave bus
);

  localparam int              BCD_W     = 4 * DIGITS;
  localparam int              CNT_W     = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_WIDTH - 1);
  localparam logic [63:0]     BCD_MAX   = bcd_max(DIGITS);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t               state_q;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BIN_WIDTH-1:0] bin_d;
  logic [BCD_W-1:0]     scratch_q;
  logic [BCD_W-1:0]     scratch_adj;
  logic [BCD_W-1:0]     scratch_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_pend_q;
  logic [BCD_W-1:0]     bcd_q;
  logic                 overflow_q;
  logic                 done_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (scratch_adj[4*g +: 4])
    );
  end

  // Carry out of the top digit is dropped; ovf_pend_q already flags those inputs.
  assign scratch_d = {scratch_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
  assign bin_d     = {bin_q[BIN_WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            bin_q      <= bus.in_value;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (64'(bus.in_value) > BCD_MAX);
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bin_q     <= bin_d;
          scratch_q <= scratch_d;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            bcd_q      <= ovf_pend_q ? ALL_NINES : scratch_d;
            overflow_q <= ovf_pend_q;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q == SHIFT);
  assign bus.bcd      = bcd_q;
  assign bus.overflow = overflow_q;
  assign bus.done     = done_q;
  assign bus.state    = state_q;

endmodule
